// File: rtl/seq_game_controller.sv
// seq_game_controller
// Runs one round of the Sequence Memory game. Each round appends one LFSR
// symbol to the sequence buffer and plays the whole buffer back as timed LED
// flashes. It then checks the player's presses against the buffer, one
// press at a time.
// All outputs are registered. They are computed from next-state values, so
// they always equal a Moore decode of the current registered state.

module seq_game_controller #(
    parameter int unsigned MAX_LEN    = 32,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned LW         = $clog2(MAX_LEN + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    rand_num,
    input  logic          btn_valid,
    input  logic [1:0]    btn_id,
    output logic          led_valid,
    output logic [1:0]    led_id,
    output logic          awaiting_input,
    output logic [LW-1:0] level,
    output logic          game_over,
    output logic          game_won
);

    localparam int unsigned IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned T_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        INPUT    = 3'd4,
        LOSE     = 3'd5,
        WON      = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    seq_q [MAX_LEN];
    logic [1:0]    seq_d [MAX_LEN];

    logic          led_valid_q, led_valid_d;
    logic [1:0]    led_id_q, led_id_d;
    logic          awaiting_q, awaiting_d;
    logic [LW-1:0] level_q, level_d;
    logic          game_over_q, game_over_d;
    logic          game_won_q, game_won_d;

    logic          last_sym;

    // Next-state, buffer, and registered-output computation
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        seq_d    = seq_q;
        last_sym = (LW'(idx_q) == (len_q - LW'(1)));

        case (state_q)
            IDLE, LOSE, WON: begin
                if (start) begin
                    state_d = ADD;
                    len_d   = '0;
                end
            end
            ADD: begin
                seq_d[len_q[IW-1:0]] = rand_num;
                len_d   = len_q + LW'(1);
                idx_d   = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = SHOW_OFF;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SHOW_OFF: begin
                if (timer_q == OFF_LAST) begin
                    if (last_sym) begin
                        idx_d   = '0;
                        state_d = INPUT;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            INPUT: begin
                if (btn_valid) begin
                    if (btn_id != seq_q[idx_q]) begin
                        state_d = LOSE;
                    end else if (!last_sym) begin
                        idx_d = idx_q + IW'(1);
                    end else if (len_q < LEN_MAX) begin
                        state_d = ADD;
                    end else begin
                        state_d = WON;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The timer restarts from zero whenever the state changes.
        if (state_d != state_q) begin
            timer_d = '0;
        end

        led_valid_d = (state_d == SHOW_ON);
        led_id_d    = (state_d == SHOW_ON) ? seq_d[idx_d] : 2'd0;
        awaiting_d  = (state_d == INPUT);
        level_d     = len_d;
        game_over_d = (state_d == LOSE);
        game_won_d  = (state_d == WON);
    end

    // State, counters, sequence buffer and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            seq_q       <= '{default: '0};
            led_valid_q <= 1'b0;
            led_id_q    <= '0;
            awaiting_q  <= 1'b0;
            level_q     <= '0;
            game_over_q <= 1'b0;
            game_won_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            seq_q       <= seq_d;
            led_valid_q <= led_valid_d;
            led_id_q    <= led_id_d;
            awaiting_q  <= awaiting_d;
            level_q     <= level_d;
            game_over_q <= game_over_d;
            game_won_q  <= game_won_d;
        end
    end

    assign led_valid      = led_valid_q;
    assign led_id         = led_id_q;
    assign awaiting_input = awaiting_q;
    assign level          = level_q;
    assign game_over      = game_over_q;
    assign game_won       = game_won_q;

endmodule

// File: tb/tb_seq_game_controller.sv
// Testbench for seq_game_controller with small parameters.
// A behavioural game model predicts every output on every cycle. Each
// playback is modelled as a precomputed list of per-cycle LED values.

module tb_seq_game_controller;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned ON_C    = 3;
    localparam int unsigned OFF_C   = 2;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    logic          clock;
    logic          reset;
    logic          start;
    logic [1:0]    rand_num;
    logic          btn_valid;
    logic [1:0]    btn_id;
    logic          led_valid;
    logic [1:0]    led_id;
    logic          awaiting_input;
    logic [LW-1:0] level;
    logic          game_over;
    logic          game_won;

    int n_checks = 0;
    int n_fail   = 0;

    seq_game_controller #(
        .MAX_LEN   (MAX_LEN),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .rand_num      (rand_num),
        .btn_valid     (btn_valid),
        .btn_id        (btn_id),
        .led_valid     (led_valid),
        .led_id        (led_id),
        .awaiting_input(awaiting_input),
        .level         (level),
        .game_over     (game_over),
        .game_won      (game_won)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_ADD, M_PLAY, M_INPUT, M_LOSE, M_WON} mode_t;
    mode_t      mode;
    int         m_len;
    int         m_pos;
    logic [1:0] m_seq[$];
    logic [2:0] script[$];   // {lit, symbol} for each playback cycle
    logic [2:0] cur;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode  = M_IDLE;
            m_len = 0;
            m_pos = 0;
            cur   = 3'b000;
            m_seq.delete();
            script.delete();
        end else begin
            case (mode)
                M_IDLE, M_LOSE, M_WON: begin
                    if (start) begin
                        mode  = M_ADD;
                        m_len = 0;
                        m_seq.delete();
                    end
                end
                M_ADD: begin
                    m_seq.push_back(rand_num);
                    m_len = m_len + 1;
                    script.delete();
                    for (int i = 0; i < m_seq.size(); i++) begin
                        repeat (ON_C) script.push_back({1'b1, m_seq[i]});
                        repeat (OFF_C) script.push_back(3'b000);
                    end
                    cur  = script.pop_front();
                    mode = M_PLAY;
                end
                M_PLAY: begin
                    if (script.size() == 0) begin
                        mode  = M_INPUT;
                        m_pos = 0;
                        cur   = 3'b000;
                    end else begin
                        cur = script.pop_front();
                    end
                end
                M_INPUT: begin
                    if (btn_valid) begin
                        if (btn_id != m_seq[m_pos]) mode = M_LOSE;
                        else if (m_pos < m_len - 1) m_pos = m_pos + 1;
                        else if (m_len < MAX_LEN) mode = M_ADD;
                        else mode = M_WON;
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [8:0] exp_vec, act_vec;
    always @(negedge clock) begin
        exp_vec = {(mode == M_PLAY) ? cur : 3'b000, mode == M_INPUT,
                   m_len[LW-1:0], mode == M_LOSE, mode == M_WON};
        act_vec = {led_valid, led_id, awaiting_input, level, game_over, game_won};
        n_checks++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t: got %b required %b (lv,id,await,level,over,won)",
                     $time, act_vec, exp_vec);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] id);
        btn_valid = 1'b1;
        btn_id    = id;
        tick();
        btn_valid = 1'b0;
    endtask

    task automatic wait_input();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (awaiting_input) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_input: got awaiting_input=0 required 1 within 100 cycles");
        end
    endtask

    logic [2:0] pb_exp [5];

    initial begin
        pb_exp[0] = 3'b110; pb_exp[1] = 3'b110; pb_exp[2] = 3'b110;
        pb_exp[3] = 3'b000; pb_exp[4] = 3'b000;

        reset = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_id = 2'd0; rand_num = 2'd0;
        repeat (3) tick();
        check("reset_outputs",
              {led_valid, led_id, awaiting_input, level, game_over, game_won}, 32'h0);
        reset = 1'b1;
        tick();

        // Start latency, then reset asserted mid-SHOW_ON
        rand_num = 2'd2;
        pulse_start();
        check("add_cycle_dark", {led_valid, level}, {1'b0, 3'd0});
        tick();
        check("first_lit_2_after_start", {led_valid, led_id, level}, {1'b1, 2'd2, 3'd1});
        tick();
        reset = 1'b0;
        #1;
        check("async_reset_mid_show",
              {led_valid, led_id, awaiting_input, level, game_over, game_won}, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Playback timing: 3 lit, 2 dark, then input
        rand_num = 2'd2;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("playback_cycle_%0d", i), {led_valid, led_id}, pb_exp[i]);
        end
        tick();
        check("input_after_playback", {awaiting_input, level}, {1'b1, 3'd1});

        // start during INPUT is ignored
        pulse_start();
        check("start_ignored_in_input", {awaiting_input, level}, {1'b1, 3'd1});

        // Correct round; a press during SHOW_ON is ignored
        rand_num = 2'd1;
        press(2'd2);
        check("add_keeps_level", {awaiting_input, level}, {1'b0, 3'd1});
        tick();
        btn_valid = 1'b1; btn_id = 2'd3;
        tick();
        btn_valid = 1'b0;
        check("btn_ignored_in_show", {led_valid, led_id, game_over}, {1'b1, 2'd2, 1'b0});
        wait_input();
        check("level_after_round2", level, 32'd2);

        // start and press together in INPUT: only the press counts
        start = 1'b1; btn_valid = 1'b1; btn_id = 2'd2;
        tick();
        start = 1'b0; btn_valid = 1'b0;
        check("start_with_press", {awaiting_input, level, game_over}, {1'b1, 3'd2, 1'b0});
        rand_num = 2'd0;
        press(2'd1);
        wait_input();
        check("level_after_round3", level, 32'd3);

        // Round 4, then win
        rand_num = 2'd3;
        press(2'd2); press(2'd1); press(2'd0);
        wait_input();
        check("level_after_round4", level, 32'd4);
        press(2'd2); press(2'd1); press(2'd0); press(2'd3);
        check("game_won", {game_won, awaiting_input, level}, {1'b1, 1'b0, 3'd4});
        repeat (5) tick();
        check("won_holds_no_add", {game_won, led_valid, level}, {1'b1, 1'b0, 3'd4});

        // Restart from WON
        pulse_start();
        check("restart_clears_won", {game_won, level}, {1'b0, 3'd0});
        wait_input();
        check("restart_level1", level, 32'd1);

        // Wrong press with sequence {3}
        press(2'd0);
        check("wrong_press_lose", {game_over, awaiting_input, level}, {1'b1, 1'b0, 3'd1});
        press(2'd3); press(2'd1);
        check("lose_ignores_press", {game_over, level}, {1'b1, 3'd1});
        pulse_start();
        check("restart_clears_over", game_over, 32'd0);
        wait_input();
        check("restart_after_lose_level", level, 32'd1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
